// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single-ported unified I/D memory of the multicycle CPU between
//   the CPU datapath (fetch/LW/SW) and an external port (debug loader / DMA).
//   Each grant runs IDLE -> ACCESS (MEM_LAT cycles) -> RESP (one-cycle ack)
//   -> IDLE, so back-to-back accesses take MEM_LAT+2 cycles.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request (req held until cpu_ack)
//   cpu_ack, cpu_rdata         CPU completion pulse, last CPU read data
//   ext_req/we/addr/wdata      external request (req held until ext_ack)
//   ext_ack, ext_rdata         external completion pulse, last ext read data
//   mem_en/we/addr/wdata       memory macro controls (addr/wdata 0 when idle)
//   mem_rdata                  memory read data, valid in last ACCESS cycle
//   busy                       transaction in progress (ACCESS or RESP)
//   owner                      current or last grant (0 = CPU, 1 = ext)
//
// Build option
//   MEM_ARB_ROUND_ROBIN_EN     when defined, contention alternates between
//                              ports instead of always favouring the CPU.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_ack,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          owner_q;
  logic          grant_ext;
  logic          contend;

  assign contend = cpu_req & ext_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_grant records the winner of the most recent contention only, so a
  // loser that is serviced alone afterwards does not lose its turn again.
  logic last_grant;
  assign grant_ext = ext_req & (~cpu_req | ~last_grant);
`else
  assign grant_ext = ext_req & ~cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      owner_q   <= 1'b0;
      cpu_rdata <= '0;
      ext_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req | ext_req) begin
            owner_q <= grant_ext;
            we_q    <= grant_ext ? ext_we    : cpu_we;
            addr_q  <= grant_ext ? ext_addr  : cpu_addr;
            wdata_q <= grant_ext ? ext_wdata : cpu_wdata;
            cnt     <= CNT_INIT;
            state   <= S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (contend) last_grant <= grant_ext;
`endif
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (owner_q) ext_rdata <= mem_rdata;
              else         cpu_rdata <= mem_rdata;
            end
            state <= S_RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        // RESP always returns to IDLE; that idle cycle lets a requester drop
        // req after its ack without being granted again.
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // contend is only consumed by the round-robin build.
  logic unused_contend;
  assign unused_contend = contend;

  always_comb begin
    busy      = (state != S_IDLE);
    mem_en    = (state == S_ACCESS);
    // write strobe only in the first ACCESS cycle (cnt still at its load value)
    mem_we    = mem_en & we_q & (cnt == CNT_INIT);
    mem_addr  = mem_en ? addr_q  : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    cpu_ack   = (state == S_RESP) & ~owner_q;
    ext_ack   = (state == S_RESP) &  owner_q;
    owner     = owner_q;
  end

endmodule
